// File: rtl/pl_mem_sum_master.sv
// rtl/pl_mem_sum_master.sv - memory-summing bus master: reads a word array, writes its 32-bit sum back
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           command strobe, only looked at in IDLE
//   base, count     byte address of first source word, number of words to sum
//   dest            byte address that receives the sum
//   mem_addr        byte address to the data memory
//   mem_dout        write data to the memory
//   mem_din         combinational read data from the memory
//   mem_we          memory write enable (WRITE state only)
//   busy            high whenever the engine is not IDLE
//   done            one-cycle pulse after the write-back
//   err             one-cycle pulse after a misaligned command
//   sum             last completed sum, held until the next completion
module pl_mem_sum_master #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      dest,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_dout,
    input  logic [31:0]      mem_din,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      ptr;
    logic [31:0]      dst;
    logic [31:0]      acc;
    logic [CNT_W-1:0] rem;
    logic             aligned;
    logic             accept;

    assign aligned = (base[1:0] == 2'b00) && (dest[1:0] == 2'b00);
    assign accept  = (state == IDLE) && start && aligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // A zero-length command skips straight to the write-back of 0.
                    state_nxt = (count != '0) ? READ : WRITE;
                end
            end
            READ: begin
                if (rem == CNT_W'(1)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            dst <= '0;
            acc <= '0;
            rem <= '0;
            sum <= '0;
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && !aligned;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr <= base;
                        rem <= count;
                        dst <= dest;
                        acc <= '0;
                    end
                end
                READ: begin
                    // Pointer wraps modulo 2^32 on purpose.
                    acc <= acc + mem_din;
                    ptr <= ptr + 32'd4;
                    rem <= rem - CNT_W'(1);
                end
                WRITE: begin
                    sum <= acc;
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        mem_addr = '0;
        mem_dout = '0;
        mem_we   = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            READ: begin
                mem_addr = ptr;
            end
            WRITE: begin
                mem_addr = dst;
                mem_dout = acc;
                mem_we   = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pl_mem_sum_master.sv
// tb/tb_pl_mem_sum_master.sv - scoreboard bench for pl_mem_sum_master
module tb_pl_mem_sum_master;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      base;
    logic [CNT_W-1:0] count;
    logic [31:0]      dest;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_dout;
    logic [31:0]      mem_din;
    logic             mem_we;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      sum;

    pl_mem_sum_master #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .count    (count),
        .dest     (dest),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sum      (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256-word memory; byte address bits [9:2] select the word (higher bits alias).
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    assign mem_din = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_dout;
    end

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;
    logic [31:0] last_sum = 32'd0;

    logic [31:0] rd_q  [$];
    logic [63:0] wr_q  [$];
    logic [31:0] sum_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[9:2];
    endfunction

    // Reference model: sum of count words from base stepping by 4 (mod 2^32),
    // all reads taken from memory as it stood before the write-back.
    task automatic push_model(input logic [31:0] b, input int c, input logic [31:0] d);
        logic [31:0] s;
        logic [31:0] a;
        s = 32'd0;
        for (int i = 0; i < c; i++) begin
            a = b + 32'(4 * i);
            rd_q.push_back(a);
            s = s + ref_mem[idx(a)];
        end
        wr_q.push_back({d, s});
        sum_q.push_back(s);
        ref_mem[idx(d)] = s;
        last_sum = s;
    endtask

    // Monitor: compares every bus cycle and completion against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && !mem_we && !done) begin
                if (rd_q.size() == 0) check("unexpected_read", mem_addr, 32'hxxxx_xxxx);
                else check("rd_addr", mem_addr, rd_q.pop_front());
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {31'd0, mem_we}, 32'd0);
                end else begin
                    logic [63:0] w;
                    w = wr_q.pop_front();
                    check("wr_addr", mem_addr, w[63:32]);
                    check("wr_data", mem_dout, w[31:0]);
                end
            end
            if (done) begin
                if (sum_q.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
                else check("sum", sum, sum_q.pop_front());
            end
        end
    end

    task automatic do_cmd(input logic [31:0] b, input int c, input logic [31:0] d, input bit inject);
        int n;
        push_model(b, c, d);
        @(posedge clk);
        #1;
        base  = b;
        count = CNT_W'(c);
        dest  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = inject;
        base  = $urandom;
        dest  = $urandom;
        count = CNT_W'($urandom);
        n = 0;
        while (n < c + 10) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done) break;
        end
        check("done_latency", 32'(n), 32'(c + 2));
    endtask

    task automatic bad_cmd(input logic [31:0] b, input logic [31:0] d);
        @(posedge clk);
        #1;
        base  = b;
        dest  = d;
        count = CNT_W'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("err_clear", {31'd0, err}, 32'd0);
        check("err_busy2", {31'd0, busy}, 32'd0);
        check("err_sum_hold", sum, last_sum);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = 32'd0;
        count = '0;
        dest  = 32'd0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_dout", mem_dout, 32'd0);
        check("rst_sum", sum, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Known array
        ref_mem[idx(32'h50)] = 32'ha3;  mem[idx(32'h50)] = 32'ha3;
        ref_mem[idx(32'h54)] = 32'h27;  mem[idx(32'h54)] = 32'h27;
        ref_mem[idx(32'h58)] = 32'h79;  mem[idx(32'h58)] = 32'h79;
        ref_mem[idx(32'h5c)] = 32'h115; mem[idx(32'h5c)] = 32'h115;
        do_cmd(32'h50, 4, 32'h60, 1'b0);
        check("t1_sum_const", sum, 32'h258);
        check("t1_mem60", mem[idx(32'h60)], 32'h258);

        // Zero-length command
        do_cmd(32'h0, 0, 32'h64, 1'b0);
        check("t2_sum_zero", sum, 32'h0);

        // Overflow wraps mod 2^32
        ref_mem[0] = 32'hFFFF_FFFF; mem[0] = 32'hFFFF_FFFF;
        ref_mem[1] = 32'h2;         mem[1] = 32'h2;
        do_cmd(32'h0, 2, 32'h08, 1'b0);
        check("t3_sum_const", sum, 32'h1);

        // Misaligned commands
        bad_cmd(32'h52, 32'h70);
        bad_cmd(32'h50, 32'h61);

        // Reset during the second READ cycle
        rd_q.push_back(32'h100);
        rd_q.push_back(32'h104);
        @(posedge clk);
        #1;
        base  = 32'h100;
        count = CNT_W'(4);
        dest  = 32'h120;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_sum = 32'd0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_sum", sum, 32'd0);
        check("abort_rdq", 32'(rd_q.size()), 32'd0);
        rd_q.delete();
        check("abort_nowrite", mem[idx(32'h120)], ref_mem[idx(32'h120)]);
        do_cmd(32'h100, 4, 32'h120, 1'b0);

        // Start pulsed while busy is ignored; address wrap
        do_cmd(32'h200, 5, 32'h240, 1'b1);
        do_cmd(32'hFFFF_FFFC, 2, 32'h30, 1'b0);
        do_cmd(32'h80, 63, 32'h84, 1'b0);

        // Random commands, dest may overlap source
        for (int k = 0; k < 25; k++) begin
            do_cmd($urandom & 32'hFFFF_FFFC, $urandom_range(0, 12),
                   $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("rdq_empty", 32'(rd_q.size()), 32'd0);
        check("wrq_empty", 32'(wr_q.size()), 32'd0);
        check("sumq_empty", 32'(sum_q.size()), 32'd0);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
